// File: rtl/avalon_body_regs.sv
// avalon_body_regs: Avalon-MM double-buffered body registers with a 2-stage is_ball pixel renderer.
// Optional build macro BODY_SWAP_IRQ_EN adds the swap-done irq output and CTRL bit3/bit2 behaviour.
module avalon_body_regs #(
   parameter int N_BODIES = 8,
   parameter int ADDR_W   = 5
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              avs_chipselect,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [3:0]        avs_byteenable,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   input  logic              VGA_VS,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
`ifdef BODY_SWAP_IRQ_EN
   output logic              is_ball,
   output logic              irq
`else
   output logic              is_ball
`endif
);

   localparam logic [31:0]       BODY_MASK = 32'h83FF_FFFF;
   localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(N_BODIES);

   logic [31:0] r_shadow [N_BODIES];
   logic [26:0] r_active [N_BODIES];   // {valid, radius, y, x}
   logic        r_pending;
   logic [7:0]  r_frame_cnt;
   logic [31:0] r_readdata;
   logic        r_vs_meta, r_vs_sync, r_vs_prev;
   logic        r_is_ball;

   logic [10:0] r_dx  [N_BODIES];
   logic [10:0] r_dy  [N_BODIES];
   logic [5:0]  r_rad [N_BODIES];
   logic        r_val [N_BODIES];

   logic        w_wr, w_rd, w_ctrl_wr, w_commit, w_vs_fall, w_swap, w_irq_bit;
   logic [31:0] w_lane_mask, w_ctrl_word, w_rd_word;
   logic [10:0] w_abs_dx [N_BODIES];
   logic [10:0] w_abs_dy [N_BODIES];
   logic [21:0] w_d2     [N_BODIES];
   logic [11:0] w_r2     [N_BODIES];
   logic [N_BODIES-1:0] w_hit;

   assign w_wr        = avs_chipselect & avs_write;
   assign w_rd        = avs_chipselect & avs_read;
   assign w_ctrl_wr   = w_wr && (avs_address == CTRL_ADDR);
   assign w_commit    = w_ctrl_wr & avs_byteenable[0] & avs_writedata[0];
   assign w_vs_fall   = r_vs_prev & ~r_vs_sync;
   assign w_swap      = w_vs_fall & r_pending;
   assign w_lane_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                         {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};

`ifdef BODY_SWAP_IRQ_EN
   logic r_irq;
   logic w_irq_clr;

   assign w_irq_clr = w_ctrl_wr & avs_byteenable[0] & avs_writedata[2];
   assign w_irq_bit = r_irq;
   assign irq       = r_irq;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)       r_irq <= 1'b0;
      else if (w_swap)    r_irq <= 1'b1;   // set beats a same-cycle clear
      else if (w_irq_clr) r_irq <= 1'b0;
   end
`else
   assign w_irq_bit = 1'b0;
`endif

   assign w_ctrl_word = {16'd0, r_frame_cnt, 4'd0, w_irq_bit, 1'b0, r_pending, 1'b0};

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
   // this is what lets a swap copy the shadow word as it was before a same-cycle write.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_vs_meta   <= 1'b0;
         r_vs_sync   <= 1'b0;
         r_vs_prev   <= 1'b0;
         r_pending   <= 1'b0;
         r_frame_cnt <= 8'd0;
      end else begin
         r_vs_meta <= VGA_VS;
         r_vs_sync <= r_vs_meta;
         r_vs_prev <= r_vs_sync;
         r_pending <= (r_pending & ~w_vs_fall) | w_commit;
         if (w_vs_fall) r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   // NOTE: the register banks are reset explicitly because software-visible reset state
   // (valid=0 in every slot) is required; these are flops, not an inferred RAM.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < N_BODIES; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BODIES; i++) begin
            if (w_wr && (avs_address == ADDR_W'(i)))
               r_shadow[i] <= ((r_shadow[i] & ~w_lane_mask) | (avs_writedata & w_lane_mask)) & BODY_MASK;
            if (w_swap)
               r_active[i] <= {r_shadow[i][31], r_shadow[i][25:0]};
         end
      end
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_rd_word = '0;
      for (int i = 0; i < N_BODIES; i++)
         if (avs_address == ADDR_W'(i)) w_rd_word = r_shadow[i];
      if (avs_address == CTRL_ADDR) w_rd_word = w_ctrl_word;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)  r_readdata <= '0;
      else if (w_rd) r_readdata <= w_rd_word;
   end

   // S1: per-body signed offsets from the active bank
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < N_BODIES; i++) begin
            r_dx[i]  <= '0;
            r_dy[i]  <= '0;
            r_rad[i] <= '0;
            r_val[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < N_BODIES; i++) begin
            r_dx[i]  <= {1'b0, DrawX} - {1'b0, r_active[i][9:0]};
            r_dy[i]  <= {1'b0, DrawY} - {1'b0, r_active[i][19:10]};
            r_rad[i] <= r_active[i][25:20];
            r_val[i] <= r_active[i][26];
         end
      end
   end

   // S2: squared distance against squared radius, OR-reduced across bodies
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < N_BODIES; i++) begin
         w_abs_dx[i] = r_dx[i][10] ? 11'(-r_dx[i]) : r_dx[i];
         w_abs_dy[i] = r_dy[i][10] ? 11'(-r_dy[i]) : r_dy[i];
         w_d2[i]     = 22'(w_abs_dx[i]) * 22'(w_abs_dx[i]) + 22'(w_abs_dy[i]) * 22'(w_abs_dy[i]);
         w_r2[i]     = 12'(r_rad[i]) * 12'(r_rad[i]);
         w_hit[i]    = r_val[i] && (w_d2[i] <= 22'(w_r2[i]));
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_is_ball <= 1'b0;
      else          r_is_ball <= |w_hit;
   end

   assign avs_readdata = r_readdata;
   assign is_ball      = r_is_ball;

endmodule

// File: tb/tb_avalon_body_regs.sv
// Scoreboard bench for avalon_body_regs: stimulus pushes expected read/pixel results,
// a negedge monitor pops and compares when readdata / is_ball become valid.
module tb_avalon_body_regs;

   localparam logic [4:0] CTRL = 5'd8;
`ifdef BODY_SWAP_IRQ_EN
   localparam logic [31:0] IRQ = 32'h8;
`else
   localparam logic [31:0] IRQ = 32'h0;
`endif

   logic        Clk, Reset_n;
   logic        avs_chipselect, avs_read, avs_write;
   logic [4:0]  avs_address;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_writedata, avs_readdata;
   logic        VGA_VS;
   logic [9:0]  DrawX, DrawY;
   logic        is_ball;
`ifdef BODY_SWAP_IRQ_EN
   logic        irq;
`endif

   avalon_body_regs #(.N_BODIES(8), .ADDR_W(5)) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .avs_chipselect(avs_chipselect),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_byteenable(avs_byteenable),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .VGA_VS        (VGA_VS),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .is_ball       (is_ball)
`ifdef BODY_SWAP_IRQ_EN
      ,.irq          (irq)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t rd_q[$];
   exp_t pix_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_err    = 0;
   logic pix_req;
   logic rd_v1, pix_v1, pix_v2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: output valid with no expected entry queued", name);
   endtask

   // Track when each output becomes valid: readdata 1 cycle after a read, is_ball 2 after a pixel.
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_v1  <= 1'b0;
         pix_v1 <= 1'b0;
         pix_v2 <= 1'b0;
      end else begin
         rd_v1  <= avs_chipselect & avs_read;
         pix_v1 <= pix_req;
         pix_v2 <= pix_v1;
      end
   end

   always @(negedge Clk) begin
      if (rd_v1) begin
         if (rd_q.size() == 0) unexpected("readdata");
         else begin
            mon_e = rd_q.pop_front();
            check(mon_e.name, avs_readdata, mon_e.exp);
         end
      end
      if (pix_v2) begin
         if (pix_q.size() == 0) unexpected("is_ball");
         else begin
            mon_e = pix_q.pop_front();
            check(mon_e.name, {31'd0, is_ball}, mon_e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic bus_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
      avs_chipselect = 1'b1;
      avs_write      = 1'b1;
      avs_address    = addr;
      avs_writedata  = data;
      avs_byteenable = be;
      tick();
      avs_chipselect = 1'b0;
      avs_write      = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
      rd_q.push_back('{name: name, exp: exp});
      avs_chipselect = 1'b1;
      avs_read       = 1'b1;
      avs_address    = addr;
      tick();
      avs_chipselect = 1'b0;
      avs_read       = 1'b0;
   endtask

   task automatic pixel(input int x, input int y, input logic exp, input string name);
      pix_q.push_back('{name: name, exp: {31'd0, exp}});
      DrawX   = 10'(x);
      DrawY   = 10'(y);
      pix_req = 1'b1;
      tick();
      pix_req = 1'b0;
   endtask

   // One full vsync pulse: low long enough to pass the synchroniser, then back high.
   task automatic vsync_pulse();
      VGA_VS = 1'b0;
      repeat (4) tick();
      VGA_VS = 1'b1;
      repeat (3) tick();
   endtask

   // Drive VS low and return in the cycle where the synchronised falling edge is seen.
   task automatic vsync_to_fall();
      VGA_VS = 1'b0;
      tick();
      tick();
   endtask

   task automatic vsync_finish();
      tick();
      VGA_VS = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0; avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
      avs_address = '0; avs_byteenable = '0; avs_writedata = '0;
      VGA_VS = 1'b1; DrawX = '0; DrawY = '0; pix_req = 1'b0;
      repeat (3) tick();
      Reset_n = 1'b1;
      tick();
      check("reset_readdata", avs_readdata, 32'h0);
      check("reset_is_ball", {31'd0, is_ball}, 32'h0);
      tick();

      // Shadow write without commit: no effect on pixels, frame count advances
      bus_write(5'd0, 32'h80A0_C864, 4'hF);           // valid, r=10, y=50, x=100
      bus_read(5'd0, 32'h80A0_C864, "body0_shadow");
      vsync_pulse();
      pixel(100, 50, 1'b0, "no_commit_centre");
      bus_read(CTRL, 32'h0000_0100, "ctrl_frame1");

      // Commit, pending visible one cycle later, swap on vsync
      bus_write(CTRL, 32'h1, 4'hF);
      bus_read(CTRL, 32'h0000_0102, "ctrl_pending");
      vsync_pulse();
      bus_read(CTRL, 32'h0000_0200 | IRQ, "ctrl_after_swap");
`ifdef BODY_SWAP_IRQ_EN
      check("irq_set", {31'd0, irq}, 32'h1);
`endif
      bus_write(CTRL, 32'h4, 4'hF);
`ifdef BODY_SWAP_IRQ_EN
      tick();
      check("irq_clear", {31'd0, irq}, 32'h0);
`endif
      bus_read(CTRL, 32'h0000_0200, "ctrl_irq_cleared");
      pixel(100, 50, 1'b1, "hit_centre");
      pixel(110, 50, 1'b1, "hit_edge_x");
      pixel(111, 50, 1'b0, "miss_x");
      pixel(107, 57, 1'b1, "hit_diag");
      pixel(108, 58, 1'b0, "miss_diag");
      pixel(90, 50, 1'b1, "hit_edge_negx");
      pixel(89, 50, 1'b0, "miss_negx");
      pixel(100, 40, 1'b1, "hit_edge_negy");
      pixel(100, 39, 1'b0, "miss_negy");

      // Byte lanes: reserved bits read 0, partial writes touch only enabled lanes
      bus_write(5'd1, 32'hFFFF_FFFF, 4'hF);
      bus_read(5'd1, 32'h83FF_FFFF, "body1_mask");
      bus_write(5'd1, 32'h1234_5678, 4'b0001);
      bus_read(5'd1, 32'h83FF_FF78, "body1_be0");
      bus_write(5'd1, 32'h0000_0000, 4'b1000);
      bus_read(5'd1, 32'h00FF_FF78, "body1_be3");

      // Commit on the vs_fall cycle: no swap now, pending kept
      bus_write(5'd2, 32'h8003_212C, 4'hF);           // valid, r=0, y=200, x=300
      bus_write(5'd3, 32'h8030_0802, 4'hF);           // valid, r=3, y=2, x=2
      vsync_to_fall();
      bus_write(CTRL, 32'h1, 4'hF);
      vsync_finish();
      bus_read(CTRL, 32'h0000_0302, "ctrl_commit_collision");
      pixel(300, 200, 1'b0, "collision_no_swap");
      pixel(0, 0, 1'b0, "collision_no_swap_b3");
      vsync_pulse();
      bus_read(CTRL, 32'h0000_0400 | IRQ, "ctrl_deferred_swap");
      bus_write(CTRL, 32'h4, 4'hF);
      pixel(300, 200, 1'b1, "r0_centre");
      pixel(301, 200, 1'b0, "r0_right");
      pixel(300, 199, 1'b0, "r0_above");
      pixel(0, 0, 1'b1, "no_clamp_origin");
      pixel(5, 3, 1'b0, "b3_miss");
      pixel(100, 50, 1'b1, "b0_still_hit");

      // Double commit, then shadow write on the vs_fall cycle
      bus_write(CTRL, 32'h1, 4'hF);
      bus_write(CTRL, 32'h1, 4'hF);
      vsync_to_fall();
      bus_write(5'd0, 32'h0, 4'hF);
      vsync_finish();
      bus_read(CTRL, 32'h0000_0500 | IRQ, "ctrl_single_swap");
      bus_write(CTRL, 32'h4, 4'hF);
      bus_read(5'd0, 32'h0, "body0_write_landed");
      pixel(100, 50, 1'b1, "active_got_prewrite");
      bus_write(CTRL, 32'h1, 4'hF);
      vsync_pulse();
      bus_write(CTRL, 32'h4, 4'hF);
      bus_read(CTRL, 32'h0000_0600, "ctrl_frame6");
      pixel(100, 50, 1'b0, "b0_invalidated");

      // Async reset mid-activity
      bus_write(CTRL, 32'h1, 4'hF);
      bus_read(CTRL, 32'h0000_0602, "ctrl_before_reset");
      DrawX = 10'd0;
      DrawY = 10'd0;
      repeat (3) tick();
      #2 Reset_n = 1'b0;
      #1;
      check("midreset_readdata", avs_readdata, 32'h0);
      check("midreset_is_ball", {31'd0, is_ball}, 32'h0);
`ifdef BODY_SWAP_IRQ_EN
      check("midreset_irq", {31'd0, irq}, 32'h0);
`endif
      rd_q.delete();
      pix_q.delete();
      tick();
      Reset_n = 1'b1;
      tick();
      bus_read(CTRL, 32'h0, "ctrl_after_reset");
      bus_read(5'd0, 32'h0, "body0_after_reset");
      bus_read(5'd3, 32'h0, "body3_after_reset");
      pixel(0, 0, 1'b0, "pixel_after_reset");

      // frame_cnt wrap
      repeat (255) vsync_pulse();
      bus_read(CTRL, 32'h0000_FF00, "frame_255");
      vsync_pulse();
      bus_read(CTRL, 32'h0, "frame_wrap");

      for (int i = 0; i < 10; i++)
         if (rd_q.size() != 0 || pix_q.size() != 0) tick();
      check("drain_rd", rd_q.size(), 32'h0);
      check("drain_pix", pix_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
